// File: rtl/vram_arbiter.sv
// VRAM port arbiter between CPU bus accesses and the PPU fetcher.
// State | meaning: IDLE idle/arbitrate, CPU_RD CPU read (addr + capture), CPU_WR CPU write, PPU_ADDR fetch addr, PPU_CAP fetch capture/ack.
module vram_arbiter #(
    parameter logic [15:0] VRAM_BASE = 16'h8000,
    parameter int          VRAM_SIZE = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [15:0] cpu_A,
    input  logic [7:0]  cpu_Di,
    output logic [7:0]  cpu_Do,
    input  logic        cpu_cs,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        ppu_req,
    input  logic [12:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_data,
    output logic [12:0] vram_A,
    output logic [7:0]  vram_Do,
    input  logic [7:0]  vram_Di,
    output logic        vram_cs,
    output logic        vram_rd_n,
    output logic        vram_wr_n,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, PPU_ADDR, PPU_CAP} state_t;

    state_t      state, state_n;
    logic        rd_phase;
    logic [16:0] cpu_off;
    logic        in_win, strobe_rd, strobe_wr, strobe_act, strobe_prev, cpu_ev;
    logic        pend_valid, pend_wr;
    logic [12:0] pend_addr;
    logic [7:0]  pend_data;
    logic        req_valid, req_wr;
    logic [12:0] req_addr;
    logic [7:0]  req_data;
    logic        arb, take, refuse, grant_ppu;
    logic [7:0]  ppu_data_q;

    // 17-bit difference: bit 16 set means the address is below the window
    assign cpu_off    = {1'b0, cpu_A} - {1'b0, VRAM_BASE};
    assign in_win     = !cpu_off[16] && (cpu_off < 17'(VRAM_SIZE));
    assign strobe_rd  = !cpu_rd_n && cpu_wr_n;
    assign strobe_wr  = cpu_rd_n && !cpu_wr_n;
    assign strobe_act = cpu_cs && in_win && (strobe_rd || strobe_wr);
    assign cpu_ev     = strobe_act && !strobe_prev;

    // A fresh event is newer than the slot, so it takes its place
    assign req_valid = cpu_ev || pend_valid;
    assign req_wr    = cpu_ev ? strobe_wr       : pend_wr;
    assign req_addr  = cpu_ev ? cpu_off[12:0]   : pend_addr;
    assign req_data  = cpu_ev ? cpu_Di          : pend_data;

    always_comb begin
        state_n   = state;
        arb       = 1'b0;
        take      = 1'b0;
        refuse    = 1'b0;
        grant_ppu = 1'b0;
        case (state)
            IDLE:     arb = 1'b1;
            CPU_WR:   begin state_n = IDLE; arb = 1'b1; end
            CPU_RD:   if (rd_phase) begin state_n = IDLE; arb = 1'b1; end
            PPU_ADDR: state_n = PPU_CAP;
            PPU_CAP:  state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        // The last cycle of a CPU access doubles as an arbitration slot so a
        // waiting fetch follows immediately; PPU_CAP is excluded because the
        // fetcher still holds ppu_req during its ack cycle.
        if (arb) begin
            if (req_valid && mode != 2'd3) begin
                take    = 1'b1;
                state_n = req_wr ? CPU_WR : CPU_RD;
            end else if (ppu_req) begin
                grant_ppu = 1'b1;
                state_n   = PPU_ADDR;
            end else if (req_valid) begin
                take   = 1'b1;
                refuse = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_phase    <= 1'b0;
            strobe_prev <= 1'b0;
            pend_valid  <= 1'b0;
            pend_wr     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            cpu_Do      <= 8'hFF;
            ppu_data_q  <= '0;
            drop_count  <= '0;
            vram_cs     <= 1'b0;
            vram_rd_n   <= 1'b1;
            vram_wr_n   <= 1'b1;
            vram_A      <= '0;
            vram_Do     <= '0;
        end else begin
            rd_phase    <= (state == CPU_RD) && !rd_phase;
            strobe_prev <= strobe_act;

            if (take) begin
                pend_valid <= 1'b0;
            end else if (cpu_ev) begin
                pend_valid <= 1'b1;
                pend_wr    <= strobe_wr;
                pend_addr  <= cpu_off[12:0];
                pend_data  <= cpu_Di;
            end

            vram_cs   <= 1'b0;
            vram_rd_n <= 1'b1;
            vram_wr_n <= 1'b1;
            if (take && !refuse) begin
                vram_cs <= 1'b1;
                vram_A  <= req_addr;
                if (req_wr) begin
                    vram_wr_n <= 1'b0;
                    vram_Do   <= req_data;
                end else begin
                    vram_rd_n <= 1'b0;
                end
            end else if (grant_ppu) begin
                vram_cs   <= 1'b1;
                vram_rd_n <= 1'b0;
                vram_A    <= ppu_addr;
            end

            if (state == CPU_RD && rd_phase) cpu_Do <= vram_Di;
            if (refuse && !req_wr)           cpu_Do <= 8'hFF;
            if (refuse && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

            if (state == PPU_CAP) ppu_data_q <= vram_Di;
        end
    end

    // RAM output is already registered; bypass it during the ack cycle so
    // data and ack line up, then hold the captured byte.
    assign ppu_ack  = (state == PPU_CAP);
    assign ppu_data = ppu_ack ? vram_Di : ppu_data_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter VRAM_BASE, default 16'h8000: first CPU address that decodes to VRAM.
REQ-002 Parameter VRAM_SIZE, default 8192: VRAM depth in bytes; decoded window is VRAM_BASE to VRAM_BASE+VRAM_SIZE-1.
REQ-003 clock  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mode  in  2  current PPU mode (0 hblank, 1 vblank, 2 OAM search, 3 transfer).
REQ-006 cpu_A  in  16  CPU address.
REQ-007 cpu_Di  in  8  CPU write data.
REQ-008 cpu_Do  out  8  CPU read data, registered.
REQ-009 cpu_cs, cpu_rd_n, cpu_wr_n  in  1 each  CPU chip select (active-high), read strobe (active-low), write strobe (active-low).
REQ-010 ppu_req  in  1  fetcher read request, level, held until ppu_ack.
REQ-011 ppu_addr  in  13  fetcher VRAM byte offset, stable while ppu_req is high.
REQ-012 ppu_ack  out  1  one-cycle pulse; ppu_data is valid in the same cycle.
REQ-013 ppu_data  out  8  fetcher read data, registered, held until the next ack.
REQ-014 vram_A  out  13  VRAM address.
REQ-015 vram_Do  out  8  VRAM write data.
REQ-016 vram_Di  in  8  VRAM read data; valid one cycle after the address cycle (synchronous RAM).
REQ-017 vram_cs, vram_rd_n, vram_wr_n  out  1 each  VRAM select (active-high), read (active-low), write (active-low).
REQ-018 drop_count  out  8  saturating count of CPU accesses refused because of the mode 3 lock.

Function
REQ-019 A CPU event is the first cycle of cpu_cs && cpu_A inside the VRAM window && (!cpu_rd_n xor !cpu_wr_n); the strobe is edge-detected, so a held strobe produces exactly one access.
REQ-020 When both strobes are low, the event is ignored.
REQ-021 A CPU event latches the address, data and direction into a one-entry pending slot.
REQ-022 A new CPU event that arrives while the pending slot is full overwrites the slot.
REQ-023 States: IDLE, CPU_RD, CPU_WR, PPU_ADDR, PPU_CAP.
REQ-024 IDLE with a pending CPU access and mode != 3 moves to CPU_RD or CPU_WR and clears the slot.
REQ-025 IDLE with a pending CPU access and mode == 3 refuses the access.
REQ-026 A refused read loads cpu_Do = 8'hFF.
REQ-027 A refused write is discarded.
REQ-028 Every refusal increments drop_count, which saturates at 255.
REQ-029 A refusal clears the slot and keeps the state machine in IDLE.
REQ-030 IDLE with ppu_req high and no grantable CPU access moves to PPU_ADDR.
REQ-031 Priority outside mode 3: a CPU access wins over the fetcher.
REQ-032 Priority in mode 3: the fetcher wins; a CPU access cannot be granted in mode 3.
REQ-033 CPU_WR lasts one cycle: vram_cs=1, vram_wr_n=0, vram_A and vram_Do from the slot; then IDLE.
REQ-034 CPU_RD, first cycle: address phase with vram_rd_n=0.
REQ-035 CPU_RD, second cycle: cpu_Do <= vram_Di, then IDLE; total latency is 2 cycles from grant.
REQ-036 PPU_ADDR drives vram_A=ppu_addr, vram_cs=1, vram_rd_n=0.
REQ-037 PPU_CAP captures ppu_data <= vram_Di and asserts ppu_ack for exactly one cycle, then IDLE.
REQ-038 The fetcher's minimum request-to-ack latency is 2 cycles.
REQ-039 The mode is sampled only at grant; a change of mode during a granted access does not abort it.
REQ-040 ppu_req falling before ack: the in-flight read completes and ack still pulses; the fetcher ignores it.
REQ-041 Outside an active state: vram_cs=0, vram_rd_n=1, vram_wr_n=1, vram_A and vram_Do hold their last value.
REQ-042 vram_A = (cpu_A - VRAM_BASE) truncated to 13 bits.
REQ-043 Non-VRAM CPU addresses never create events and leave cpu_Do unchanged.

Reset
REQ-044 Reset returns the state machine to IDLE and clears the pending slot and the strobe-edge history.
REQ-045 On reset: cpu_Do=8'hFF, ppu_data=8'h00, ppu_ack=0, drop_count=0, vram_cs=0, vram_rd_n=1, vram_wr_n=1, vram_A=0, vram_Do=0.
REQ-046 Reset during any state aborts it without a write strobe, an ack or a cpu_Do update on the following cycle.

Verification
REQ-047 Scenario mode=0, CPU write cpu_A=16'h8010, Di=8'h5A, strobe held 4 cycles -> exactly one vram_wr_n pulse with vram_A=13'h0010, vram_Do=8'h5A.
REQ-048 Scenario: then a CPU read of 16'h8010 with vram_Di returning 8'h5A -> cpu_Do=8'h5A 2 cycles after grant.
REQ-049 Scenario mode=3, CPU read 16'h9000 and CPU write 16'h9001 -> cpu_Do=8'hFF, no vram_wr_n pulse, drop_count=2.
REQ-050 Scenario mode=0, CPU write and ppu_req (addr 13'h1800) in the same cycle -> CPU write first; PPU address next cycle; ppu_ack 3 cycles after the request.
REQ-051 Scenario: 300 refused accesses in mode 3 -> drop_count=255.
REQ-052 Scenario: reset asserted in PPU_ADDR -> no ppu_ack; all outputs at their reset values the cycle after reset.
